// File: rtl/iir_ch_sched_if.sv
// Bundle between the channel front-ends / banked IIR core and iir_ch_sched.
// master = front-ends plus filter core side, slave = scheduler side.
interface iir_ch_sched_if #(
  parameter int unsigned NB_DATA = 16,
  parameter int unsigned N_CH    = 4,
  parameter int unsigned NB_CH   = 2
);
  logic [N_CH-1:0]         i_req;
  logic [N_CH*NB_DATA-1:0] i_x;
  logic [N_CH-1:0]         o_ack;
  logic                    o_flt_en;
  logic [NB_DATA-1:0]      o_flt_x;
  logic [NB_CH-1:0]        o_flt_ch;
  logic [NB_DATA-1:0]      i_flt_y;
  logic [NB_DATA-1:0]      o_y;
  logic                    o_y_valid;
  logic [NB_CH-1:0]        o_y_ch;
  logic                    o_busy;

  modport master (
    output i_req, i_x, i_flt_y,
    input  o_ack, o_flt_en, o_flt_x, o_flt_ch, o_y, o_y_valid, o_y_ch, o_busy
  );

  modport slave (
    input  i_req, i_x, i_flt_y,
    output o_ack, o_flt_en, o_flt_x, o_flt_ch, o_y, o_y_valid, o_y_ch, o_busy
  );
endinterface

// File: rtl/iir_ch_sched.sv
// Round-robin scheduler time-sharing one channel-banked IIR core among N_CH requesters.
// Define IIR_SCHED_FIXED_PRIO_EN for fixed priority (lowest requesting index wins).
module iir_ch_sched #(
  parameter int unsigned NB_DATA = 16,
  parameter int unsigned N_CH    = 4,
  parameter int unsigned NB_CH   = 2,
  parameter int unsigned LATENCY = 1
) (
  input logic           clock,
  input logic           i_rst,
  iir_ch_sched_if.slave bus
);

  localparam int unsigned NB_CNT = $clog2(LATENCY + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [NB_CNT-1:0]  cnt_q, cnt_d;
  logic [N_CH-1:0]    ack_q, ack_d;
  logic               flt_en_q, flt_en_d;
  logic [NB_DATA-1:0] flt_x_q, flt_x_d;
  logic [NB_CH-1:0]   flt_ch_q, flt_ch_d;
  logic [NB_DATA-1:0] y_q, y_d;
  logic [NB_CH-1:0]   y_ch_q, y_ch_d;
  logic               y_valid_q, y_valid_d;
  logic               busy_q, busy_d;
  logic [NB_CH-1:0]   grant;
  logic [NB_DATA-1:0] x_sel;
`ifndef IIR_SCHED_FIXED_PRIO_EN
  logic [NB_CH-1:0]   ptr_q, ptr_d;
`endif

  // First requesting channel at or after start, wrapping modulo N_CH.
  function automatic logic [NB_CH-1:0] pick(input logic [N_CH-1:0]  req,
                                            input logic [NB_CH-1:0] start);
    logic [NB_CH-1:0] g;
    logic [NB_CH-1:0] idx;
    logic             found;
    g     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx = NB_CH'((32'(start) + i) % N_CH);
      if (!found && req[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
    return g;
  endfunction

`ifdef IIR_SCHED_FIXED_PRIO_EN
  assign grant = pick(bus.i_req, NB_CH'(0));
`else
  assign grant = pick(bus.i_req, ptr_q);
`endif

  always_comb begin
    x_sel = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (grant == NB_CH'(k)) x_sel = bus.i_x[k*NB_DATA +: NB_DATA];
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ack_d     = '0;
    flt_en_d  = 1'b0;
    flt_x_d   = flt_x_q;
    flt_ch_d  = flt_ch_q;
    y_d       = y_q;
    y_ch_d    = y_ch_q;
    y_valid_d = 1'b0;
    busy_d    = busy_q;
`ifndef IIR_SCHED_FIXED_PRIO_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.i_req) begin
          state_d      = ISSUE;
          flt_ch_d     = grant;
          flt_x_d      = x_sel;
          ack_d[grant] = 1'b1;
          flt_en_d     = 1'b1;
          busy_d       = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = NB_CNT'(LATENCY);
`ifndef IIR_SCHED_FIXED_PRIO_EN
        ptr_d   = (flt_ch_q == NB_CH'(N_CH - 1)) ? '0 : flt_ch_q + NB_CH'(1);
`endif
      end
      WAIT: begin
        if (cnt_q == NB_CNT'(1)) begin
          state_d   = IDLE;
          y_d       = bus.i_flt_y;
          y_ch_d    = flt_ch_q;
          y_valid_d = 1'b1;
          busy_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - NB_CNT'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ack_q     <= '0;
      flt_en_q  <= 1'b0;
      flt_x_q   <= '0;
      flt_ch_q  <= '0;
      y_q       <= '0;
      y_ch_q    <= '0;
      y_valid_q <= 1'b0;
      busy_q    <= 1'b0;
`ifndef IIR_SCHED_FIXED_PRIO_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      flt_en_q  <= flt_en_d;
      flt_x_q   <= flt_x_d;
      flt_ch_q  <= flt_ch_d;
      y_q       <= y_d;
      y_ch_q    <= y_ch_d;
      y_valid_q <= y_valid_d;
      busy_q    <= busy_d;
`ifndef IIR_SCHED_FIXED_PRIO_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign bus.o_ack     = ack_q;
  assign bus.o_flt_en  = flt_en_q;
  assign bus.o_flt_x   = flt_x_q;
  assign bus.o_flt_ch  = flt_ch_q;
  assign bus.o_y       = y_q;
  assign bus.o_y_ch    = y_ch_q;
  assign bus.o_y_valid = y_valid_q;
  assign bus.o_busy    = busy_q;

endmodule

// File: tb/tb_iir_ch_sched.sv
// Directed self-checking bench for iir_ch_sched (N_CH=4, LATENCY=1).
// The filter core is stood in for by returning o_flt_x ^ mask exactly LATENCY cycles after o_flt_en.
module tb_iir_ch_sched;

  logic clock = 1'b0;
  logic i_rst;
  always #5 clock = ~clock;

  iir_ch_sched_if #(.NB_DATA(16), .N_CH(4), .NB_CH(2)) bus ();

  iir_ch_sched #(.NB_DATA(16), .N_CH(4), .NB_CH(2), .LATENCY(1)) dut (
    .clock (clock),
    .i_rst (i_rst),
    .bus   (bus)
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  logic        pend   = 1'b0;
  logic [15:0] pend_val = '0;
  logic [15:0] mask   = '0;
  logic [15:0] xs [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; sample #1 after the edge and play the filter core.
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    if (pend) begin
      bus.i_flt_y = pend_val;
      pend = 1'b0;
    end else begin
      bus.i_flt_y = 16'hDEAD;
    end
    if (bus.o_flt_en === 1'b1) begin
      pend     = 1'b1;
      pend_val = bus.o_flt_x ^ mask;
    end
  endtask

  task automatic wait_issue(input string tag, output logic [1:0] ch);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.o_flt_en !== 1'b1 && n < 20);
    chk({tag, "_issue_seen"}, 32'(bus.o_flt_en), 32'd1);
    ch = bus.o_flt_ch;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ch;
    int pulses;
    int issues, yv, n, last;
    int acks [4];

    xs[0] = 16'h1111; xs[1] = 16'h2222; xs[2] = 16'h3333; xs[3] = 16'h4444;
    i_rst       = 1'b1;
    bus.i_req   = '0;
    bus.i_x     = '0;
    bus.i_flt_y = '0;

    // Reset then idle
    step(); step();
    chk("rst_ack",     32'(bus.o_ack),     32'd0);
    chk("rst_flt_en",  32'(bus.o_flt_en),  32'd0);
    chk("rst_flt_x",   32'(bus.o_flt_x),   32'd0);
    chk("rst_flt_ch",  32'(bus.o_flt_ch),  32'd0);
    chk("rst_y",       32'(bus.o_y),       32'd0);
    chk("rst_y_valid", 32'(bus.o_y_valid), 32'd0);
    chk("rst_y_ch",    32'(bus.o_y_ch),    32'd0);
    chk("rst_busy",    32'(bus.o_busy),    32'd0);
    i_rst  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.o_ack !== 4'd0 || bus.o_flt_en !== 1'b0 || bus.o_busy !== 1'b0 ||
          bus.o_y_valid !== 1'b0) pulses++;
    end
    chk("idle_no_activity", 32'(pulses), 32'd0);

    // Single request on ch2, filter echoes the sample
    mask      = 16'h0000;
    bus.i_x   = {16'h3333, 16'h0010, 16'h2222, 16'h1111};
    bus.i_req = 4'b0100;
    step();
    chk("single_ack",    32'(bus.o_ack),    32'h4);
    chk("single_flt_en", 32'(bus.o_flt_en), 32'd1);
    chk("single_flt_ch", 32'(bus.o_flt_ch), 32'd2);
    chk("single_flt_x",  32'(bus.o_flt_x),  32'h0010);
    chk("single_busy",   32'(bus.o_busy),   32'd1);
    bus.i_req = 4'b0000;
    step();
    chk("single_wait_en",    32'(bus.o_flt_en),  32'd0);
    chk("single_wait_ack",   32'(bus.o_ack),     32'd0);
    chk("single_wait_busy",  32'(bus.o_busy),    32'd1);
    chk("single_wait_yv",    32'(bus.o_y_valid), 32'd0);
    step();
    chk("single_y_valid", 32'(bus.o_y_valid), 32'd1);
    chk("single_y",       32'(bus.o_y),       32'h0010);
    chk("single_y_ch",    32'(bus.o_y_ch),    32'd2);
    chk("single_busy_lo", 32'(bus.o_busy),    32'd0);
    step();
    chk("single_yv_pulse", 32'(bus.o_y_valid), 32'd0);
    chk("single_y_hold",   32'(bus.o_y),       32'h0010);

    // Reset so the pointer starts at ch0
    i_rst = 1'b1;
    step();
    chk("rst2_y", 32'(bus.o_y), 32'd0);
    i_rst = 1'b0;

`ifdef IIR_SCHED_FIXED_PRIO_EN
    mask      = 16'hA5A5;
    bus.i_x   = {xs[3], xs[2], xs[1], xs[0]};
    bus.i_req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      wait_issue("fixed", ch);
      chk("fixed_grant_ch0", 32'(ch), 32'd0);
      chk("fixed_ack_ch0",   32'(bus.o_ack), 32'h1);
    end
    bus.i_req = 4'b0000;
    step(); step();
`else
    // Round-robin fairness with all channels requesting
    mask      = 16'hA5A5;
    bus.i_x   = {xs[3], xs[2], xs[1], xs[0]};
    bus.i_req = 4'b1111;
    issues = 0; yv = 0; n = 0; last = 0;
    for (int k = 0; k < 4; k++) acks[k] = 0;
    while (yv < 16 && n < 200) begin
      step();
      n++;
      if (bus.o_flt_en === 1'b1) begin
        chk("rr_grant", 32'(bus.o_flt_ch), 32'(issues % 4));
        chk("rr_ack",   32'(bus.o_ack),    32'(1 << (issues % 4)));
        chk("rr_x",     32'(bus.o_flt_x),  32'(xs[issues % 4]));
        if (issues > 0) chk("rr_spacing", 32'(cyc - last), 32'd3);
        last = cyc;
        for (int k = 0; k < 4; k++) if (bus.o_ack[k] === 1'b1) acks[k]++;
        issues++;
        if (issues == 16) bus.i_req = 4'b0000;
      end
      if (bus.o_y_valid === 1'b1) begin
        chk("rr_y_ch", 32'(bus.o_y_ch), 32'(yv % 4));
        chk("rr_y",    32'(bus.o_y),    32'(xs[yv % 4] ^ 16'hA5A5));
        yv++;
      end
    end
    chk("rr_results", 32'(yv), 32'd16);
    for (int k = 0; k < 4; k++) chk("rr_ack_count", 32'(acks[k]), 32'd4);

    // Pointer wrap: last grant was ch3, so ch0 goes before ch3
    bus.i_req = 4'b1001;
    wait_issue("wrap_first", ch);
    chk("wrap_first_ch", 32'(ch), 32'd0);
    wait_issue("wrap_second", ch);
    chk("wrap_second_ch",  32'(ch),          32'd3);
    chk("wrap_second_ack", 32'(bus.o_ack),   32'h8);
    bus.i_req = 4'b0000;
    step(); step();
    chk("wrap_y", 32'(bus.o_y), 32'(xs[3] ^ 16'hA5A5));

    // Reset while waiting on ch1 drops that result and re-arms the pointer
    bus.i_req = 4'b0010;
    wait_issue("midrst", ch);
    chk("midrst_ch", 32'(ch), 32'd1);
    bus.i_req = 4'b0000;
    step();
    chk("midrst_busy_wait", 32'(bus.o_busy), 32'd1);
    i_rst = 1'b1;
    step();
    chk("midrst_busy",   32'(bus.o_busy),    32'd0);
    chk("midrst_y_valid", 32'(bus.o_y_valid), 32'd0);
    chk("midrst_y",      32'(bus.o_y),       32'd0);
    i_rst  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.o_y_valid !== 1'b0) pulses++;
    end
    chk("midrst_no_result", 32'(pulses), 32'd0);
    bus.i_req = 4'b0110;
    wait_issue("post_rst", ch);
    chk("post_rst_ch", 32'(ch), 32'd1);
    bus.i_req = 4'b0000;
    step(); step();
    chk("post_rst_y_valid", 32'(bus.o_y_valid), 32'd1);
    chk("post_rst_y",       32'(bus.o_y),       32'(xs[1] ^ 16'hA5A5));
    chk("post_rst_y_ch",    32'(bus.o_y_ch),    32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
